serial_operand_feeder: RTL and testbench
========================================

Name: serial_operand_feeder

Overview:
Upstream stage of the bit-serial adder. It accepts two WIDTH-bit operands through a valid/ready handshake. It then shifts both operands out LSB-first, one bit pair per enabled cycle, on a_bit/b_bit. After the last data bit it drives one flush slot of a_bit=b_bit=0, so the downstream adder emits its carry-out as bit WIDTH and returns to its no-carry state before the next frame.

Parameters:
WIDTH, 8, operand width in bits; legal range 2 to 32.

Ports:
clk        input   1      clock; all state updates on rising edge
reset      input   1      asynchronous, active-high; clears all state
in_valid   input   1      operand pair a_in/b_in is presented
in_ready   output  1      feeder can accept an operand pair (high only in IDLE)
a_in       input   WIDTH  operand A, parallel
b_in       input   WIDTH  operand B, parallel
shift_en   input   1      advance enable; low holds all outputs and state
a_bit      output  1      serial operand A bit to adder input a
b_bit      output  1      serial operand B bit to adder input b
bit_valid  output  1      a_bit/b_bit carry a data bit (SHIFT state)
bit_first  output  1      current bit is bit 0 of the frame
bit_last   output  1      current bit is bit WIDTH-1 of the frame
carry_slot output  1      flush slot; the adder output this cycle is the carry-out
busy       output  1      state is not IDLE
done       output  1      one-cycle pulse when the flush slot is consumed

Behaviour:
- Reset: while reset is high, state=IDLE; shift registers a_sr and b_sr = 0; cnt = 0.
- Output values during reset: in_ready=1; all other outputs 0.
- Reset mid-frame aborts the frame immediately. No done pulse is produced.
- Registers:
  - a_sr and b_sr: WIDTH bits each.
  - cnt: $clog2(WIDTH) bits.
- a_bit = a_sr[0] and b_bit = b_sr[0] at all times. There is no combinational path from a_in/b_in to a_bit/b_bit.
- FSM states: IDLE, SHIFT, FLUSH.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load a_sr<=a_in, b_sr<=b_in, cnt<=0, go to SHIFT.
  - shift_en is ignored in IDLE.
  - a_sr and b_sr are 0 in IDLE, so a_bit=b_bit=0.
- SHIFT:
  - bit_valid=1, bit_first=(cnt==0), bit_last=(cnt==WIDTH-1).
  - When shift_en=1: shift a_sr and b_sr right with 0 fill, and increment cnt.
  - If bit_last is high in a cycle with shift_en=1, go to FLUSH.
  - When shift_en=0: hold state, registers and outputs.
  - in_valid is ignored (in_ready=0).
- FLUSH:
  - carry_slot=1 and bit_valid=0.
  - a_bit=b_bit=0; the registers are already zero after WIDTH shifts.
  - When shift_en=1: done=1 in this cycle (combinational from state&&shift_en), then go to IDLE.
  - When shift_en=0: hold.
- Latency:
  - Accept edge to first data bit on the outputs: 1 cycle.
  - Frame length with shift_en held high: WIDTH data cycles + 1 flush cycle.
  - Minimum accept-to-accept period: WIDTH+2 cycles, because IDLE lasts at least one cycle.
- The downstream adder must sample s on cycles where shift_en&&(bit_valid||carry_slot). Bit k of the sum is available in the cycle bit k is driven.
- Simultaneous events:
  - reset dominates everything.
  - in_valid in the same cycle as done is not accepted; it is accepted on the following IDLE cycle.

Decomposition:
- Shared package serial_pkg holds:
  - the state enum (IDLE=2'd0, SHIFT=2'd1, FLUSH=2'd2);
  - the localparam CNT_W=$clog2(WIDTH) helper.
- One natural sub-module, piso_shift_reg: WIDTH-bit parallel-load, right-shift, zero-fill register with load/shift enables. It is instantiated twice, once for A and once for B.
- FSM and counter live in the top.

Test Plan:
1. WIDTH=8, A=0x05, B=0x03, shift_en=1:
   - a_bit sequence 1,0,1,0,0,0,0,0 then 0; b_bit sequence 1,1,0,0,0,0,0,0 then 0.
   - bit_first on cycle 1, bit_last on cycle 8, carry_slot and done on cycle 9.
   - With the adder attached: sum 0x08, carry 0.
2. A=0xFF, B=0x01 with the adder attached: collected sum 0x00 and carry_slot bit=1. A following frame of A=0x01, B=0x01 gives sum 0x02, confirming the carry was flushed.
3. Drop shift_en for 3 cycles after bit 3 of A=0xA5: a_bit, b_bit, bit_valid and cnt hold for 3 cycles, then the sequence resumes at bit 4. Frame completes in 12 cycles.
4. Hold in_valid high with new operands during SHIFT: in_ready=0 and the operands are not loaded. The pair is accepted in the IDLE cycle after done, giving an accept-to-accept period of 10 cycles.
5. Assert reset asynchronously during bit 5:
   - Immediately: busy=0, bit_valid=0, a_bit=b_bit=0, in_ready=1. No done pulse.
   - The next frame A=0x11, B=0x22 serializes correctly.
6. Hold shift_en=0 in FLUSH for 2 cycles: carry_slot stays high, done stays 0, and done pulses only in the cycle shift_en returns to 1.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types for the bit-serial adder datapath: FSM state encoding and counter sizing.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Bit-index counter width for a frame of the given operand width.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_operand_feeder_if.sv
// Operand handshake plus serial bit stream between the feeder and the bit-serial adder.
// master = upstream driver / adder side, slave = feeder.
interface serial_operand_feeder_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             shift_en;
    logic             a_bit;
    logic             b_bit;
    logic             bit_valid;
    logic             bit_first;
    logic             bit_last;
    logic             carry_slot;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, a_in, b_in, shift_en,
        input  in_ready, a_bit, b_bit, bit_valid, bit_first, bit_last,
               carry_slot, busy, done
    );

    modport slave (
        input  in_valid, a_in, b_in, shift_en,
        output in_ready, a_bit, b_bit, bit_valid, bit_first, bit_last,
               carry_slot, busy, done
    );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register, LSB first with zero fill; load wins over shift.
// Load/shift take effect on the next edge; no backpressure, the caller gates shift_en.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_en) begin
            sr_d = par_in;
        end else if (shift_en) begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign ser_out = sr_q[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// Serializes an operand pair LSB-first, then one zero flush slot for the adder carry-out.
// First bit 1 cycle after accept; shift_en low freezes everything; in_ready only in IDLE.
module serial_operand_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_operand_feeder_if.slave  bus
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             load;
    logic             shift;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.shift_en) begin
                    shift = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (bus.shift_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // After WIDTH shifts both registers are already zero, so FLUSH and IDLE drive 0/0.
    piso_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
        .clk      (clk),
        .reset    (reset),
        .load_en  (load),
        .shift_en (shift),
        .par_in   (bus.a_in),
        .ser_out  (bus.a_bit)
    );

    piso_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
        .clk      (clk),
        .reset    (reset),
        .load_en  (load),
        .shift_en (shift),
        .par_in   (bus.b_in),
        .ser_out  (bus.b_bit)
    );

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.bit_valid  = (state_q == SHIFT);
    assign bus.bit_first  = (state_q == SHIFT) && (cnt_q == '0);
    assign bus.bit_last   = (state_q == SHIFT) && (cnt_q == LAST_IDX);
    assign bus.carry_slot = (state_q == FLUSH);
    assign bus.done       = (state_q == FLUSH) && bus.shift_en;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder with a behavioural bit-serial adder and operand scoreboard.
module tb_serial_operand_feeder;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    serial_operand_feeder_if #(.WIDTH(W)) bus ();

    serial_operand_feeder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [31:0]  cyc;
    } frame_t;

    frame_t       sb[$];
    frame_t       cur;
    int           cyc      = 0;
    int           k        = 0;
    logic         in_frame = 1'b0;
    logic         carry    = 1'b0;
    logic [W:0]   sum      = '0;
    logic [W:0]   last_sum = '0;
    int           n_done   = 0;
    int           frame_len = 0;
    int           last_acc = 0;
    int           prev_acc = 0;

    always @(posedge clk) cyc++;

    // Monitor + downstream adder model, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            in_frame = 1'b0;
            carry    = 1'b0;
            k        = 0;
        end else begin
            if (bus.bit_valid) begin
                if (!in_frame) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 1, 0);
                        cur = '0;
                    end else begin
                        cur = sb.pop_front();
                        check("accept_to_bit0", cyc - int'(cur.cyc), 1);
                    end
                    in_frame = 1'b1;
                    k        = 0;
                    sum      = '0;
                end
                check("bit_first", bus.bit_first, (k == 0));
                check("bit_last", bus.bit_last, (k == W - 1));
                check("cnt", dut.cnt_q, k);
                check("a_bit", bus.a_bit, cur.a[k]);
                check("b_bit", bus.b_bit, cur.b[k]);
                check("busy_shift", bus.busy, 1);
                check("in_ready_shift", bus.in_ready, 0);
                check("done_shift", bus.done, 0);
                if (bus.shift_en) begin
                    sum[k] = bus.a_bit ^ bus.b_bit ^ carry;
                    carry  = (bus.a_bit & bus.b_bit) | (carry & (bus.a_bit ^ bus.b_bit));
                    k++;
                end
            end else begin
                check("a_bit_zero", bus.a_bit, 0);
                check("b_bit_zero", bus.b_bit, 0);
                check("bit_first_off", bus.bit_first, 0);
                if (bus.carry_slot) begin
                    check("busy_flush", bus.busy, 1);
                    check("in_ready_flush", bus.in_ready, 0);
                    check("done_flush", bus.done, bus.shift_en);
                    if (bus.shift_en) begin
                        sum[W]    = carry;
                        carry     = 1'b0;
                        check("bits_in_frame", k, W);
                        check("sum", sum, {1'b0, cur.a} + {1'b0, cur.b});
                        last_sum  = sum;
                        frame_len = cyc - int'(cur.cyc);
                        in_frame  = 1'b0;
                        n_done++;
                    end
                end else begin
                    check("done_idle", bus.done, 0);
                    check("busy_idle", bus.busy, 0);
                    check("in_ready_idle", bus.in_ready, 1);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back('{a: bus.a_in, b: bus.b_in, cyc: 32'(cyc)});
                prev_acc = last_acc;
                last_acc = cyc;
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok = 1'b0;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int  d0 = n_done;
        bit  ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (n_done > d0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 0, 1);
        #1;
    endtask

    initial begin
        #150000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        bus.in_valid = 1'b0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        bus.shift_en = 1'b1;

        // Outputs while reset is held.
        #12;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_bit_valid", bus.bit_valid, 0);
        check("rst_a_bit", bus.a_bit, 0);
        check("rst_carry_slot", bus.carry_slot, 0);
        check("rst_done", bus.done, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: 5 + 3
        send(8'h05, 8'h03);
        wait_done(30);
        check("t1_len", frame_len, 9);
        check("t1_sum", last_sum, 9'h008);

        // 2: carry-out, then confirm the adder carry was flushed
        send(8'hFF, 8'h01);
        wait_done(30);
        check("t2_sum", last_sum, 9'h100);
        send(8'h01, 8'h01);
        wait_done(30);
        check("t2_sum_next", last_sum, 9'h002);

        // 3: stall three cycles once bits 0..3 are consumed
        send(8'hA5, 8'h5A);
        repeat (4) @(posedge clk);
        #1 bus.shift_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.shift_en = 1'b1;
        wait_done(30);
        check("t3_len", frame_len, 12);

        // 4: new pair held during SHIFT is taken only after done
        send(8'h3C, 8'hC3);
        repeat (2) @(posedge clk);
        #1;
        bus.a_in     = 8'h77;
        bus.b_in     = 8'h11;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("t4_period", last_acc - prev_acc, W + 2);
        wait_done(30);
        check("t4_sum", last_sum, 9'h088);

        // 5: asynchronous reset while bit 5 is on the wire
        send(8'h3C, 8'h20);
        repeat (5) @(posedge clk);
        #3;
        check("t5_pre_a_bit", bus.a_bit, 1);
        d0 = n_done;
        reset = 1'b1;
        #1;
        check("t5_busy", bus.busy, 0);
        check("t5_bit_valid", bus.bit_valid, 0);
        check("t5_a_bit", bus.a_bit, 0);
        check("t5_b_bit", bus.b_bit, 0);
        check("t5_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("t5_no_done", n_done, d0);
        send(8'h11, 8'h22);
        wait_done(30);
        check("t5_sum", last_sum, 9'h033);

        // 6: hold two cycles in the flush slot
        send(8'h81, 8'h81);
        repeat (8) @(posedge clk);
        #1 bus.shift_en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("t6_carry_slot", bus.carry_slot, 1);
            check("t6_done_held", bus.done, 0);
        end
        @(posedge clk);
        #1 bus.shift_en = 1'b1;
        #1 check("t6_done_pulse", bus.done, 1);
        @(posedge clk);
        #1;
        check("t6_done_gone", bus.done, 0);
        check("t6_idle", bus.in_ready, 1);
        check("t6_sum", last_sum, 9'h102);

        // A few random frames
        for (int i = 0; i < 6; i++) begin
            send(W'($urandom), W'($urandom));
            wait_done(30);
        end

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
